// File: rtl/alu_exec.sv
// Execute-stage ALU: single-cycle logic/arithmetic with a registered result, plus an iterative shift-add MUL.
// Optional MUL_EARLY_EXIT_EN: finish MUL as soon as the remaining multiplier bits are all zero.
module alu_exec #(
    parameter int WIDTH    = 32,
    parameter int MUL_STEP = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       alucontrol,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    input  logic             flush,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             out_valid,
    output logic             busy
);

    localparam int MUL_CYCLES = WIDTH / MUL_STEP;
    localparam int CW         = $clog2(MUL_CYCLES + 1);

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_MUL = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    typedef enum logic {IDLE, MUL} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [CW-1:0]    count_q, count_d;

    logic [WIDTH-1:0] alu_res;
    logic [WIDTH-1:0] step_acc;
    logic [WIDTH-1:0] mplier_shift;
    logic             mul_finish;

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q == MUL);
    assign result    = result_q;
    assign zero      = zero_q;
    assign out_valid = out_valid_q;

    always_comb begin
        alu_res = '0;
        case (alucontrol)
            OP_ADD:  alu_res = srca + srcb;
            OP_SUB:  alu_res = srca - srcb;
            OP_AND:  alu_res = srca & srcb;
            OP_OR:   alu_res = srca | srcb;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(srca) < $signed(srcb))};
            default: alu_res = '0;
        endcase
    end

    // One shift-add step: add the partial product of the low multiplier digit.
    always_comb begin
        step_acc     = acc_q + (mcand_q * WIDTH'(mplier_q[MUL_STEP-1:0]));
        mplier_shift = mplier_q >> MUL_STEP;
        mul_finish   = (count_q == CW'(1));
`ifdef MUL_EARLY_EXIT_EN
        mul_finish   = mul_finish || (mplier_shift == '0);
`else
        mul_finish   = mul_finish;
`endif
    end

    always_comb begin
        state_d     = state_q;
        result_d    = result_q;
        zero_d      = zero_q;
        out_valid_d = 1'b0;
        acc_d       = acc_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        count_d     = count_q;
        case (state_q)
            IDLE: begin
                if (in_valid && !flush) begin
                    if (alucontrol == OP_MUL) begin
                        mcand_d  = srca;
                        mplier_d = srcb;
                        acc_d    = '0;
                        count_d  = CW'(MUL_CYCLES);
                        state_d  = MUL;
                    end else begin
                        result_d    = alu_res;
                        zero_d      = (alu_res == '0);
                        out_valid_d = 1'b1;
                    end
                end
            end
            MUL: begin
                // A flush abandons the product; result keeps the previous completion.
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    acc_d    = step_acc;
                    mcand_d  = mcand_q << MUL_STEP;
                    mplier_d = mplier_shift;
                    count_d  = count_q - CW'(1);
                    if (mul_finish) begin
                        result_d    = step_acc;
                        zero_d      = (step_acc == '0);
                        out_valid_d = 1'b1;
                        state_d     = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            result_q    <= '0;
            zero_q      <= 1'b1;
            out_valid_q <= 1'b0;
            acc_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            out_valid_q <= out_valid_d;
            acc_q       <= acc_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            count_q     <= count_d;
        end
    end

endmodule

// File: doc/alu_exec.md
Name: alu_exec

Overview:
- Execute-stage ALU of the pipelined core; consumes the 3-bit alucontrol value delivered in the E stage by the ALU decoder, together with the two source operands.
- Single-cycle logic/arithmetic ops complete with a registered result one cycle after acceptance.
- MUL runs on an iterative shift-add engine over several cycles. During that time the block drops in_ready so hazard logic stalls D/E.

Parameters:
- WIDTH, 32, operand/result width in bits.
- MUL_STEP, 4, multiplier bits consumed per MUL cycle; must divide WIDTH; MUL_CYCLES = WIDTH/MUL_STEP (8 by default).

Ports:
- clk  input  1  core clock, all state on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  E-stage op present.
- in_ready  output  1  block can accept an op this cycle.
- alucontrol  input  3  op code: 010 add, 110 sub, 011 mul, 000 and, 001 or, 111 slt.
- srca  input  WIDTH  operand A.
- srcb  input  WIDTH  operand B.
- flush  input  1  kill the in-flight op (branch redirect).
- result  output  WIDTH  registered result.
- zero  output  1  registered (result == 0).
- out_valid  output  1  one-cycle pulse, result/zero valid.
- busy  output  1  MUL in progress (state MUL).

Behaviour:
- Reset: when reset is high at a clock edge, all outputs and state take their reset values at that edge: state=IDLE, result=0, zero=1, out_valid=0, busy=0, internal accumulator/count=0. Reset overrides flush and in_valid, including mid-MUL; the aborted MUL produces no out_valid.
- States: IDLE, MUL. in_ready = (state==IDLE). busy = (state==MUL).
- Acceptance: in_valid & in_ready at an edge.
- Non-MUL op accepted at edge k:
  - add/sub wrap mod 2^WIDTH; and/or bitwise; slt = signed(srca) < signed(srcb) zero-extended to WIDTH.
  - Codes 100, 101 or any X produce result=0.
  - After edge k: result/zero updated, out_valid=1 for exactly that cycle, state stays IDLE.
- MUL accepted at edge k:
  - Load mcand=srca, mplier=srcb, acc=0, count=MUL_CYCLES; state→MUL; out_valid=0 after edge k.
  - Each MUL-state edge: acc += mcand * mplier[MUL_STEP-1:0] (low WIDTH bits kept); mcand <<= MUL_STEP; mplier >>= MUL_STEP; count -= 1.
  - On the edge where count goes 1→0: result=final acc (low WIDTH bits of srca*srcb; signed/unsigned identical), zero updated, out_valid=1, state→IDLE.
  - Latency: out_valid high after edge k+MUL_CYCLES (8 by default).
  - in_ready returns high in the same cycle as out_valid, so back-to-back issue is allowed.
- out_valid is never held for more than one cycle. There is no downstream backpressure.
- result/zero hold their last value until the next completion.
- flush:
  - In MUL: state→IDLE at that edge, no out_valid, result unchanged.
  - In IDLE: takes priority over in_valid; nothing accepted, no out_valid that cycle.
  - flush coinciding with the final MUL step: the result is discarded and out_valid=0.
- in_valid while in MUL is ignored (not accepted; upstream holds the op).

Optional Feature:
- Macro MUL_EARLY_EXIT_EN.
- Defined: completion also occurs on the first MUL edge at which the shifted mplier becomes 0. At least 1 MUL cycle is always taken, so MUL latency is between 1 and MUL_CYCLES cycles; results are identical to the full run.
- Undefined: MUL always takes exactly MUL_CYCLES cycles regardless of operands.

Test Plan:
- Reset release, then add 5+7 issued at edge k → after edge k: out_valid=1, result=12, zero=0; next cycle out_valid=0.
- sub 3-3 → result=0, zero=1. slt srca=0xFFFFFFFF, srcb=1 → result=1. add 0xFFFFFFFF+1 → result=0, zero=1.
- mul 0x00001234*0x00000056 accepted at k → in_ready=0 and busy=1 for edges k+1..k+7; after edge k+8: out_valid=1, result=0x00061D78. An add presented at k+8 is accepted, and its result appears after k+9.
- mul 0xFFFFFFFF*2 → result=0xFFFFFFFE. With MUL_EARLY_EXIT_EN: mul 9*2 completes after edge k+1; without it, completes after k+8.
- flush asserted at edge k+4 of a MUL → no out_valid, result keeps its prior value, in_ready=1 after k+4. The same scenario with reset instead of flush → result=0, zero=1.
- alucontrol=3'b100 with srca=srcb=0xA → result=0, zero=1, out_valid=1.
